// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer,
// mid-bit sampling on an oversampling tick (ena_i), and start-glitch
// and framing-error detection.
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frames, PARITY state present, parity_err_o live
//   undefined -> 8N1 frames, parity_err_o tied low
//
// Tick numbering: tick_q holds the index of the *upcoming* ena tick,
// counted from the start-detection tick (index 0). Every sample point
// below is therefore an absolute tick index inside the frame.

module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ena_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       busy_o
);

    localparam int HALF   = OVERSAMPLE / 2;
    localparam int TICK_W = $clog2(OVERSAMPLE * 10);

`ifdef UART_RX_PARITY_EN
    localparam int STOP_BIT_IDX = 10;
    localparam logic [TICK_W-1:0] PARITY_PT = TICK_W'(HALF + 9 * OVERSAMPLE);
`else
    localparam int STOP_BIT_IDX = 9;
`endif

    localparam logic [TICK_W-1:0] START_PT = TICK_W'(HALF);
    localparam logic [TICK_W-1:0] STOP_PT  = TICK_W'(HALF + STOP_BIT_IDX * OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_e;

    // Synchronizer flops; both idle high so reset never looks like a start bit
    logic rx_meta_q;
    logic rx_sync_q;

    state_e            state_q,      state_d;
    logic [TICK_W-1:0] tick_q,       tick_d;
    logic [2:0]        bit_cnt_q,    bit_cnt_d;
    logic [7:0]        shift_q,      shift_d;
    logic [7:0]        data_q,       data_d;
    logic              valid_q,      valid_d;
    logic              frame_err_q,  frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q,    par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    // Midpoint tick of the data bit currently being collected
    logic [TICK_W-1:0] data_pt;
    assign data_pt = TICK_W'(HALF + (int'(bit_cnt_q) + 1) * OVERSAMPLE);

    // Two-flop synchronizer bringing the asynchronous line into clk_i
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame sequencing: next state, tick/bit counters, shift register and pulses
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        if (ena_i) begin
            tick_d = tick_q + TICK_W'(1);

            case (state_q)
                IDLE: begin
                    tick_d = '0;
                    if (!rx_sync_q) begin
                        // This tick is index 0, so the next one is index 1
                        state_d   = START;
                        tick_d    = TICK_W'(1);
                        bit_cnt_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end

                START: begin
                    if (tick_q == START_PT) begin
                        // A line that is back high at mid start bit was only a glitch
                        if (rx_sync_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end

                DATA: begin
                    if (tick_q == data_pt) begin
                        shift_d   = {rx_sync_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == PARITY_PT) begin
                        // Even parity: the parity bit equals the XOR of the data bits
                        par_bad_d = rx_sync_q ^ (^shift_q);
                        state_d   = STOP;
                    end
                end
`endif

                STOP: begin
                    if (tick_q == STOP_PT) begin
                        if (!rx_sync_q) begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            parity_err_d = 1'b1;
                            state_d      = IDLE;
`endif
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end

                WAIT_HIGH: begin
                    // A break or stuck-low line must release before we hunt again
                    if (rx_sync_q) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase

            if (state_d == IDLE) begin
                tick_d = '0;
            end
        end
    end

    // State, counters, shift register and registered output pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (OVERSAMPLE = 16).
// A tick-driven behavioural receiver model predicts every output on
// every cycle; directed frames pin latency, data and error behaviour
// with literal values, then a randomized phase (random bytes, errors,
// glitches, resets and a sparse ena) runs against the model.
// Honours UART_RX_PARITY_EN in the same way as the design.

module tb_uart_rx;

    localparam int OS   = 16;
    localparam int HALF = OS / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int LAT        = 171;
    localparam int GAP        = 176;
`else
    localparam int FRAME_BITS = 10;
    localparam int LAT        = 155;
    localparam int GAP        = 160;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frameErr;
    logic       parityErr;
    logic       busy;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ena_i       (ena),
        .rx_i        (rx),
        .data_o      (data),
        .valid_o     (valid),
        .frame_err_o (frameErr),
        .parity_err_o(parityErr),
        .busy_o      (busy)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Cycle counter used to timestamp pulses
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    bit checkOn = 1'b0;

    // Model state: its own copy of the synchronized line plus predicted outputs
    logic       mS1 = 1'b1;
    logic       mS2 = 1'b1;
    logic [7:0] expData  = 8'h00;
    logic       expValid = 1'b0;
    logic       expFerr  = 1'b0;
    logic       expPerr  = 1'b0;
    logic       expBusy  = 1'b0;

    // Pulse logs (DUT and model) for directed checks
    int dValidCyc[$];
    int dValidData[$];
    int dFerrCyc[$];
    int dPerrCyc[$];
    int mValidCyc[$];

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic clearLogs();
        dValidCyc.delete();
        dValidData.delete();
        dFerrCyc.delete();
        dPerrCyc.delete();
        mValidCyc.delete();
    endtask

    // Advance the model to the next ena tick; returns the synchronized line
    // value seen at that tick, or flags a reset that aborts any frame.
    task automatic nextTick(output logic s, output bit ab);
        logic e;
        logic r;
        bit   done;
        ab   = 1'b0;
        s    = 1'b1;
        done = 1'b0;
        while (!done) begin
            @(posedge clk);
            e   = ena;
            r   = rst;
            s   = mS2;
            mS2 = mS1;
            mS1 = rx;
            expValid = 1'b0;
            expFerr  = 1'b0;
            expPerr  = 1'b0;
            if (r) begin
                mS1     = 1'b1;
                mS2     = 1'b1;
                expData = 8'h00;
                expBusy = 1'b0;
                ab      = 1'b1;
                done    = 1'b1;
            end else if (e) begin
                done = 1'b1;
            end
        end
    endtask

    task automatic waitTicks(input int n, output logic s, output bit ab);
        ab = 1'b0;
        s  = 1'b1;
        for (int i = 0; i < n; i++) begin
            nextTick(s, ab);
            if (ab) return;
        end
    endtask

    // One frame, from the tick after detection: midpoints lie every OS ticks
    task automatic modelFrame();
        logic       s;
        bit         ab;
        logic [7:0] b;
        bit         bad;
        b   = 8'h00;
        bad = 1'b0;
        expBusy = 1'b1;
        waitTicks(HALF, s, ab);
        if (ab) return;
        if (s) begin
            expBusy = 1'b0;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            waitTicks(OS, s, ab);
            if (ab) return;
            b[i] = s;
        end
`ifdef UART_RX_PARITY_EN
        waitTicks(OS, s, ab);
        if (ab) return;
        bad = (s != ^b);
`endif
        waitTicks(OS, s, ab);
        if (ab) return;
        if (!s) begin
            expFerr = 1'b1;
            do begin
                nextTick(s, ab);
                if (ab) return;
            end while (!s);
            expBusy = 1'b0;
        end else if (bad) begin
            expPerr = 1'b1;
            expBusy = 1'b0;
        end else begin
            expData  = b;
            expValid = 1'b1;
            expBusy  = 1'b0;
        end
    endtask

    // Idle hunting: any tick with the line low starts a frame
    initial begin : modelProc
        logic s;
        bit   ab;
        forever begin
            nextTick(s, ab);
            if (!ab && !s) modelFrame();
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin : compareProc
        forever begin
            @(negedge clk);
            if (checkOn) begin
                checks++;
                if ({data, valid, frameErr, parityErr, busy} ===
                    {expData, expValid, expFerr, expPerr, expBusy}) begin
                    passes++;
                end else begin
                    $display("[TB] FAIL cycleCompare cyc=%0d got data=%02h v=%b fe=%b pe=%b busy=%b expected data=%02h v=%b fe=%b pe=%b busy=%b",
                             cyc, data, valid, frameErr, parityErr, busy,
                             expData, expValid, expFerr, expPerr, expBusy);
                end
                if (valid === 1'b1) begin
                    dValidCyc.push_back(cyc);
                    dValidData.push_back(int'(data));
                end
                if (frameErr === 1'b1) dFerrCyc.push_back(cyc);
                if (parityErr === 1'b1) dPerrCyc.push_back(cyc);
                if (expValid) mValidCyc.push_back(cyc);
            end
        end
    end

    task automatic driveCycles(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            rx = v;
        end
    endtask

    // Drive one frame at one bit per OS clocks (ena held high); stop early
    // and release the line after cutAt cycles when cutAt is non-zero.
    task automatic applyStimulus(input logic [7:0] b, input logic parBit, input logic stopBit,
                                 input int cutAt, output int fallCyc);
        logic [10:0] bits;
        int          count;
        bits       = '1;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
`ifdef UART_RX_PARITY_EN
        bits[9]    = parBit;
        bits[10]   = stopBit;
`else
        bits[9]    = stopBit;
        bits[10]   = parBit;
`endif
        count   = 0;
        fallCyc = 0;
        for (int k = 0; k < FRAME_BITS; k++) begin
            for (int j = 0; j < OS; j++) begin
                @(negedge clk);
                if (count == 0) fallCyc = cyc;
                if (cutAt > 0 && count >= cutAt) begin
                    rx = 1'b1;
                    return;
                end
                rx = bits[k];
                count++;
            end
        end
    endtask

    // Hold the line at v for n ena ticks while ena toggles randomly
    task automatic holdTicks(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            do begin
                @(negedge clk);
                rx  = v;
                ena = ($urandom_range(0, 3) != 0);
            end while (!ena);
        end
    endtask

    function automatic int firstOf(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    initial begin : mainProc
        int fall;
        int fall2;

        rst = 1'b1;
        ena = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        rst     = 1'b0;
        checkOn = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("resetData",      int'(data),      0);
        checkOutput("resetValid",     int'(valid),     0);
        checkOutput("resetFrameErr",  int'(frameErr),  0);
        checkOutput("resetParityErr", int'(parityErr), 0);
        checkOutput("resetBusy",      int'(busy),      0);

        // Single 0xA5 frame: latency and data
        clearLogs();
        applyStimulus(8'hA5, 1'b0, 1'b1, 0, fall);
        driveCycles(1'b1, 40);
        checkOutput("a5ValidCount", dValidCyc.size(), 1);
        checkOutput("a5Latency", firstOf(dValidCyc) - fall, LAT);
        checkOutput("a5ModelLatency", firstOf(mValidCyc) - fall, LAT);
        checkOutput("a5Data", int'(data), 'hA5);
        checkOutput("a5ModelData", int'(expData), 'hA5);
        checkOutput("a5FrameErr", dFerrCyc.size(), 0);

        // Back-to-back 0x00 then 0xFF with no idle gap
        clearLogs();
        applyStimulus(8'h00, 1'b0, 1'b1, 0, fall);
        applyStimulus(8'hFF, 1'b0, 1'b1, 0, fall2);
        driveCycles(1'b1, 40);
        checkOutput("b2bValidCount", dValidCyc.size(), 2);
        checkOutput("b2bSpacing", (dValidCyc.size() == 2) ? dValidCyc[1] - dValidCyc[0] : -1, GAP);
        checkOutput("b2bFirstData", (dValidData.size() > 0) ? dValidData[0] : -1, 'h00);
        checkOutput("b2bSecondData", (dValidData.size() > 1) ? dValidData[1] : -1, 'hFF);

        // Four-cycle glitch on the line
        clearLogs();
        driveCycles(1'b0, 4);
        driveCycles(1'b1, 40);
        checkOutput("glitchPulses", dValidCyc.size() + dFerrCyc.size() + dPerrCyc.size(), 0);
        checkOutput("glitchBusy", int'(busy), 0);
        checkOutput("glitchData", int'(data), 'hFF);

        // 0x3C with low stop bit, then the line stays low
        clearLogs();
        applyStimulus(8'h3C, 1'b0, 1'b0, 0, fall);
        driveCycles(1'b0, 100);
        checkOutput("ferrCount", dFerrCyc.size(), 1);
        checkOutput("ferrLatency", firstOf(dFerrCyc) - fall, LAT);
        checkOutput("ferrNoValid", dValidCyc.size(), 0);
        checkOutput("ferrData", int'(data), 'hFF);
        checkOutput("ferrBusyWhileLow", int'(busy), 1);
        driveCycles(1'b1, 200);
        checkOutput("ferrBusyAfterHigh", int'(busy), 0);
        checkOutput("ferrNoNewFrame", dValidCyc.size() + dFerrCyc.size() + dPerrCyc.size(), 1);

        // Reset in the middle of 0x81, then a clean 0x42
        clearLogs();
        applyStimulus(8'h81, 1'b0, 1'b1, 3 * OS + 5, fall);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        driveCycles(1'b1, 200);
        checkOutput("abortPulses", dValidCyc.size() + dFerrCyc.size() + dPerrCyc.size(), 0);
        checkOutput("abortData", int'(data), 0);
        checkOutput("abortBusy", int'(busy), 0);
        clearLogs();
        applyStimulus(8'h42, 1'b0, 1'b1, 0, fall);
        driveCycles(1'b1, 40);
        checkOutput("after42ValidCount", dValidCyc.size(), 1);
        checkOutput("after42Latency", firstOf(dValidCyc) - fall, LAT);
        checkOutput("after42Data", int'(data), 'h42);

`ifdef UART_RX_PARITY_EN
        // 0x07 with a wrong then a right parity bit
        clearLogs();
        applyStimulus(8'h07, 1'b0, 1'b1, 0, fall);
        driveCycles(1'b1, 40);
        checkOutput("parBadCount", dPerrCyc.size(), 1);
        checkOutput("parBadLatency", firstOf(dPerrCyc) - fall, 171);
        checkOutput("parBadNoValid", dValidCyc.size(), 0);
        checkOutput("parBadData", int'(data), 'h42);
        clearLogs();
        applyStimulus(8'h07, 1'b1, 1'b1, 0, fall);
        driveCycles(1'b1, 40);
        checkOutput("parGoodValid", dValidCyc.size(), 1);
        checkOutput("parGoodNoErr", dPerrCyc.size(), 0);
        checkOutput("parGoodData", int'(data), 'h07);
`endif

        // Randomized traffic with a sparse ena, checked only by the model
        for (int f = 0; f < 40; f++) begin
            logic [7:0] b;
            int         kind;
            logic       sb;
`ifdef UART_RX_PARITY_EN
            logic       pb;
`endif
            b    = 8'($urandom);
            kind = $urandom_range(0, 11);
            if (kind == 0) begin
                holdTicks(1'b0, $urandom_range(1, 12));
            end else if (kind == 1) begin
                holdTicks(1'b0, OS);
                for (int i = 0; i < 3; i++) holdTicks(b[i], OS);
                @(negedge clk);
                rst = 1'b1;
                rx  = 1'b1;
                ena = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                sb = ($urandom_range(0, 5) != 0);
                holdTicks(1'b0, OS);
                for (int i = 0; i < 8; i++) holdTicks(b[i], OS);
`ifdef UART_RX_PARITY_EN
                pb = ^b;
                if ($urandom_range(0, 3) == 0) pb = ~pb;
                holdTicks(pb, OS);
`endif
                holdTicks(sb, OS);
                if (!sb) holdTicks(1'b0, $urandom_range(0, 30));
            end
            holdTicks(1'b1, $urandom_range(0, 20));
        end
        @(negedge clk);
        ena = 1'b1;
        driveCycles(1'b1, 400);
        checkOutput("finalBusy", int'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
